gate_self_test: RTL and testbench

- Hardware stimulus-and-check engine for the 2-input gate set (AND, OR, NOT, XOR).
- Drives shared inputs a/b through all four combinations. Samples the four gate outputs after a settle delay and compares them against the truth table.
- Reports pass/fail, an error count and the first failing vector.
- Sits beside the gate instances as an on-chip self-test. It is the checking end of the gate stimulus/response interface.

---
 rtl/gate_self_test.sv | 138 +++++++++++++
 tb/tb_gate_self_test.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/gate_self_test.sv
// On-chip self-test for the AND/OR/NOT/XOR gate set: sweeps {a,b} through all four
// vectors, checks the gate responses against the truth table and reports the result.
module gate_self_test #(
   parameter int SETTLE_CYCLES = 2,
   parameter int NUM_PASSES    = 1,
   parameter int ERR_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             y_and,
   input  logic             y_or,
   input  logic             y_not,
   input  logic             y_xor,
   output logic             a,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [1:0]       fail_vec,
   output logic [3:0]       fail_mask
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [PW-1:0] PASS_LAST   = PW'(NUM_PASSES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

   state_t           r_state;
   logic [1:0]       r_vec;
   logic [SW-1:0]    r_settleCnt;
   logic [PW-1:0]    r_passCnt;
   logic             r_a;
   logic             r_b;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [ERR_W-1:0] r_errCount;
   logic [1:0]       r_failVec;
   logic [3:0]       r_failMask;

   logic [3:0]       w_mask;
   logic             w_anyErr;
   logic [ERR_W-1:0] w_errNext;
   logic             w_lastVec;
   logic [1:0]       w_vecNext;

   // Truth-table comparison against the registered a/b currently driven to the gates.
   always_comb begin
      w_mask    = {y_xor ^ (r_a ^ r_b), y_not ^ ~r_a, y_or ^ (r_a | r_b), y_and ^ (r_a & r_b)};
      w_anyErr  = (w_mask != 4'd0);
      w_errNext = (w_anyErr && !(&r_errCount)) ? r_errCount + ERR_W'(1) : r_errCount;
      w_lastVec = (r_vec == 2'd3) && (r_passCnt == PASS_LAST);
      w_vecNext = r_vec + 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_vec       <= 2'd0;
         r_settleCnt <= '0;
         r_passCnt   <= '0;
         r_a         <= 1'b0;
         r_b         <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_errCount  <= '0;
         r_failVec   <= 2'd0;
         r_failMask  <= 4'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state     <= SETTLE;
                  r_vec       <= 2'd0;
                  r_a         <= 1'b0;
                  r_b         <= 1'b0;
                  r_settleCnt <= '0;
                  r_passCnt   <= '0;
                  r_busy      <= 1'b1;
                  r_pass      <= 1'b0;
                  r_errCount  <= '0;
                  r_failVec   <= 2'd0;
                  r_failMask  <= 4'd0;
               end
            end
            SETTLE: begin
               if (r_settleCnt == SETTLE_LAST) begin
                  r_state <= CHECK;
               end else begin
                  r_settleCnt <= r_settleCnt + SW'(1);
               end
            end
            CHECK: begin
               r_errCount <= w_errNext;
               // An error count of zero means no earlier vector failed in this run.
               if (w_anyErr && (r_errCount == '0)) begin
                  r_failVec  <= {r_a, r_b};
                  r_failMask <= w_mask;
               end
               if (w_lastVec) begin
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_errNext == '0);
               end else begin
                  r_vec       <= w_vecNext;
                  {r_a, r_b}  <= w_vecNext;
                  r_settleCnt <= '0;
                  if (r_vec == 2'd3) begin
                     r_passCnt <= r_passCnt + PW'(1);
                  end
                  r_state <= SETTLE;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign a         = r_a;
   assign b         = r_b;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign err_count = r_errCount;
   assign fail_vec  = r_failVec;
   assign fail_mask = r_failMask;

endmodule

// File: tb/tb_gate_self_test.sv
// Directed bench for gate_self_test: default instance with injectable gate faults, plus a
// small-counter two-pass instance whose gates are all inverted.
module tb_gate_self_test;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic start2 = 1'b0;
   logic stuckAnd0 = 1'b0;
   logic [3:0] invMask = 4'd0;

   logic a, b, busy, done, pass;
   logic [3:0] errCount;
   logic [1:0] failVec;
   logic [3:0] failMask;
   logic yAnd, yOr, yNot, yXor;

   logic a2, b2, busy2, done2, pass2;
   logic [1:0] errCount2;
   logic [1:0] failVec2;
   logic [3:0] failMask2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Behavioural gates with optional stuck-at / inversion faults.
   assign yAnd = stuckAnd0 ? 1'b0 : ((a & b) ^ invMask[0]);
   assign yOr  = (a | b) ^ invMask[1];
   assign yNot = ~a ^ invMask[2];
   assign yXor = (a ^ b) ^ invMask[3];

   gate_self_test dut (
      .clk(clk), .rst(rst), .start(start),
      .y_and(yAnd), .y_or(yOr), .y_not(yNot), .y_xor(yXor),
      .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
      .err_count(errCount), .fail_vec(failVec), .fail_mask(failMask)
   );

   gate_self_test #(.SETTLE_CYCLES(2), .NUM_PASSES(2), .ERR_W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2),
      .y_and(~(a2 & b2)), .y_or(~(a2 | b2)), .y_not(a2), .y_xor(~(a2 ^ b2)),
      .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(errCount2), .fail_vec(failVec2), .fail_mask(failMask2)
   );

   // One start pulse accepted at the end of cycle 0; observes cycles 1..20 at negedge.
   task automatic runOnce(output int doneAt, output int doneCnt, output int busyBad, output int abBad);
      logic [1:0] expAb;
      doneAt = -1; doneCnt = 0; busyBad = 0; abBad = 0;
      @(negedge clk); start = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (done === 1'b1) begin
            doneCnt++;
            if (doneAt < 0) doneAt = k;
         end
         if (busy !== ((k <= 12) ? 1'b1 : 1'b0)) busyBad++;
         expAb = (k <= 12) ? 2'((k - 1) / 3) : 2'd3;
         if ({a, b} !== expAb) abBad++;
      end
   endtask

   task automatic test_reset();
      tests++; if ({a, b} !== 2'b00) begin fails++; $display("[TB] FAIL reset_ab got %b want 00", {a, b}); end
      tests++; if ({busy, done, pass} !== 3'b000) begin fails++; $display("[TB] FAIL reset_flags got %b want 000", {busy, done, pass}); end
      tests++; if (errCount !== 4'd0 || failVec !== 2'd0 || failMask !== 4'd0) begin fails++;
         $display("[TB] FAIL reset_results got err=%0d vec=%b mask=%b want 0", errCount, failVec, failMask); end
   endtask

   task automatic test_good();
      int doneAt, doneCnt, busyBad, abBad;
      runOnce(doneAt, doneCnt, busyBad, abBad);
      tests++; if (doneAt !== 13) begin fails++; $display("[TB] FAIL good_done_cycle got %0d want 13", doneAt); end
      tests++; if (doneCnt !== 1) begin fails++; $display("[TB] FAIL good_done_count got %0d want 1", doneCnt); end
      tests++; if (busyBad !== 0) begin fails++; $display("[TB] FAIL good_busy_window got %0d bad cycles want 0", busyBad); end
      tests++; if (abBad !== 0) begin fails++; $display("[TB] FAIL good_ab_sequence got %0d bad cycles want 0", abBad); end
      tests++; if (pass !== 1'b1 || errCount !== 4'd0) begin fails++; $display("[TB] FAIL good_result got pass=%b err=%0d want 1/0", pass, errCount); end
      tests++; if (failVec !== 2'd0 || failMask !== 4'd0) begin fails++; $display("[TB] FAIL good_fail_info got %b/%b want 00/0000", failVec, failMask); end
   endtask

   task automatic test_and_stuck();
      int doneAt, doneCnt, busyBad, abBad;
      stuckAnd0 = 1'b1;
      runOnce(doneAt, doneCnt, busyBad, abBad);
      stuckAnd0 = 1'b0;
      tests++; if (doneAt !== 13) begin fails++; $display("[TB] FAIL and_done_cycle got %0d want 13", doneAt); end
      tests++; if (errCount !== 4'd1 || pass !== 1'b0) begin fails++; $display("[TB] FAIL and_result got err=%0d pass=%b want 1/0", errCount, pass); end
      tests++; if (failVec !== 2'b11 || failMask !== 4'b0001) begin fails++; $display("[TB] FAIL and_fail_info got %b/%b want 11/0001", failVec, failMask); end
   endtask

   task automatic test_xor_inverted();
      int doneAt, doneCnt, busyBad, abBad;
      invMask = 4'b1000;
      runOnce(doneAt, doneCnt, busyBad, abBad);
      invMask = 4'd0;
      tests++; if (errCount !== 4'd4 || pass !== 1'b0) begin fails++; $display("[TB] FAIL xor_result got err=%0d pass=%b want 4/0", errCount, pass); end
      tests++; if (failVec !== 2'b00 || failMask !== 4'b1000) begin fails++; $display("[TB] FAIL xor_fail_info got %b/%b want 00/1000", failVec, failMask); end
      runOnce(doneAt, doneCnt, busyBad, abBad);
      tests++; if (pass !== 1'b1 || errCount !== 4'd0) begin fails++; $display("[TB] FAIL xor_rerun got pass=%b err=%0d want 1/0", pass, errCount); end
      tests++; if (failVec !== 2'd0 || failMask !== 4'd0) begin fails++; $display("[TB] FAIL xor_rerun_clear got %b/%b want 00/0000", failVec, failMask); end
   endtask

   task automatic test_saturation();
      int doneAt = -1;
      @(negedge clk); start2 = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (k == 1) start2 = 1'b0;
         if (done2 === 1'b1 && doneAt < 0) doneAt = k;
      end
      tests++; if (doneAt !== 25) begin fails++; $display("[TB] FAIL sat_done_cycle got %0d want 25", doneAt); end
      tests++; if (errCount2 !== 2'd3 || pass2 !== 1'b0) begin fails++; $display("[TB] FAIL sat_result got err=%0d pass=%b want 3/0", errCount2, pass2); end
      tests++; if (failVec2 !== 2'b00 || failMask2 !== 4'b1111) begin fails++; $display("[TB] FAIL sat_fail_info got %b/%b want 00/1111", failVec2, failMask2); end
   endtask

   task automatic test_start_ignored();
      int doneAt = -1;
      int doneCnt = 0;
      @(negedge clk); start = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         start = (k == 4 || k == 12 || k == 13) ? 1'b1 : 1'b0;
         if (done === 1'b1) begin
            doneCnt++;
            if (doneAt < 0) doneAt = k;
         end
      end
      tests++; if (doneAt !== 13 || doneCnt !== 1) begin fails++; $display("[TB] FAIL ignore_start got done at %0d count %0d want 13/1", doneAt, doneCnt); end
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL ignore_start_idle got busy=%b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int doneAt[2] = '{-1, -1};
      int n = 0;
      @(negedge clk); start = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         if (done === 1'b1 && n < 2) begin doneAt[n] = k; n++; end
      end
      start = 1'b0;
      repeat (20) @(negedge clk);
      tests++; if (doneAt[0] !== 13 || doneAt[1] !== 27) begin fails++; $display("[TB] FAIL held_start got done at %0d,%0d want 13,27", doneAt[0], doneAt[1]); end
   endtask

   task automatic test_mid_reset();
      int doneAt, doneCnt, busyBad, abBad;
      int spurious = 0;
      invMask = 4'b1000;
      @(negedge clk); start = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
      end
      tests++; if (errCount !== 4'd2 || {a, b} !== 2'b10) begin fails++; $display("[TB] FAIL pre_reset got err=%0d ab=%b want 2/10", errCount, {a, b}); end
      rst = 1'b1;
      #1;
      tests++; if ({a, b} !== 2'b00 || busy !== 1'b0 || errCount !== 4'd0) begin fails++;
         $display("[TB] FAIL async_reset got ab=%b busy=%b err=%0d want 00/0/0", {a, b}, busy, errCount); end
      @(negedge clk); rst = 1'b0; invMask = 4'd0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) spurious++;
      end
      tests++; if (spurious !== 0) begin fails++; $display("[TB] FAIL reset_abort got %0d active cycles want 0", spurious); end
      runOnce(doneAt, doneCnt, busyBad, abBad);
      tests++; if (doneAt !== 13 || pass !== 1'b1 || errCount !== 4'd0) begin fails++;
         $display("[TB] FAIL post_reset_run got done=%0d pass=%b err=%0d want 13/1/0", doneAt, pass, errCount); end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      rst = 1'b0;
      test_good();
      test_and_stuck();
      test_xor_inverted();
      test_saturation();
      test_start_ignored();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
